// File: rtl/nco_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nco_pkg
// Description : Shared constants for the NCO sweep/scheduling blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package nco_pkg;

    localparam int FCW_W_DEFAULT   = 8;
    localparam int DWELL_W_DEFAULT = 16;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DWELL = 1'b1;

    localparam logic [0:0] DIR_UP   = 1'b0;
    localparam logic [0:0] DIR_DOWN = 1'b1;

endpackage : nco_pkg
`default_nettype wire

// File: rtl/nco_dwell_counter.sv
`default_nettype none
// ============================================================================
// Module      : nco_dwell_counter
// Description : Loadable down-counter with a zero flag; load wins over dec.
// Revision    : 1.0 - initial release
// ============================================================================
module nco_dwell_counter #(
    parameter int DWELL_W = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [DWELL_W-1:0] i_load_val,
    input  logic               i_dec,
    output logic               o_zero
);

    logic [DWELL_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - DWELL_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule : nco_dwell_counter
`default_nettype wire

// File: rtl/nco_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nco_sweep_ctrl
// Description : Drives the NCO tuning word through a clamped linear sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module nco_sweep_ctrl
    import nco_pkg::*;
#(
    parameter int FCW_W   = FCW_W_DEFAULT,
    parameter int DWELL_W = DWELL_W_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic               i_continuous,
    input  logic [FCW_W-1:0]   i_fcw_start,
    input  logic [FCW_W-1:0]   i_fcw_stop,
    input  logic [FCW_W-1:0]   i_fcw_step,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic [FCW_W-1:0]   o_fcw,
    output logic               o_fcw_valid,
    output logic               o_phase_clr,
    output logic               o_step,
    output logic               o_busy,
    output logic               o_done
);

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;

    logic [FCW_W-1:0]   r_cfg_start;
    logic [FCW_W-1:0]   r_cfg_stop;
    logic [FCW_W-1:0]   r_step_eff;
    logic [DWELL_W-1:0] r_dwell_eff;
    logic [0:0]         r_dir;
    logic               r_cont;

    logic [FCW_W-1:0]   r_fcw;
    logic               r_fcw_valid;
    logic               r_phase_clr;
    logic               r_step;
    logic               r_busy;
    logic               r_done;

    logic [FCW_W-1:0]   w_fcw_nxt;
    logic               w_valid_nxt;
    logic               w_phase_clr_nxt;
    logic               w_step_nxt;
    logic               w_done_nxt;
    logic               w_cfg_latch;
    logic               w_cnt_load;
    logic [DWELL_W-1:0] w_cnt_load_val;
    logic               w_cnt_dec;
    logic               w_cnt_zero;

    logic [FCW_W-1:0]   w_in_step_eff;
    logic [DWELL_W-1:0] w_in_dwell_eff;
    logic [FCW_W:0]     w_sum;
    logic [FCW_W:0]     w_diff;
    logic [FCW_W-1:0]   w_step_word;
    logic               w_at_stop;

    assign w_in_step_eff  = (i_fcw_step == '0) ? FCW_W'(1)   : i_fcw_step;
    assign w_in_dwell_eff = (i_dwell == '0)    ? DWELL_W'(1) : i_dwell;
    assign w_at_stop      = (r_fcw == r_cfg_stop);

    // Extra MSB catches carry/borrow so the word clamps instead of wrapping.
    assign w_sum  = {1'b0, r_fcw} + {1'b0, r_step_eff};
    assign w_diff = {1'b0, r_fcw} - {1'b0, r_step_eff};

    always_comb begin
        w_step_word = r_cfg_stop;
        if (r_dir == DIR_UP) begin
            if (!w_sum[FCW_W] && (w_sum[FCW_W-1:0] <= r_cfg_stop)) begin
                w_step_word = w_sum[FCW_W-1:0];
            end
        end else begin
            if (!w_diff[FCW_W] && (w_diff[FCW_W-1:0] >= r_cfg_stop)) begin
                w_step_word = w_diff[FCW_W-1:0];
            end
        end
    end

    nco_dwell_counter #(
        .DWELL_W (DWELL_W)
    ) u_dwell_counter (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // State and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_fcw       <= '0;
            r_fcw_valid <= 1'b0;
            r_phase_clr <= 1'b0;
            r_step      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fcw       <= w_fcw_nxt;
            r_fcw_valid <= w_valid_nxt;
            r_phase_clr <= w_phase_clr_nxt;
            r_step      <= w_step_nxt;
            r_busy      <= (w_state_nxt == ST_DWELL);
            r_done      <= w_done_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cfg_start <= '0;
            r_cfg_stop  <= '0;
            r_step_eff  <= '0;
            r_dwell_eff <= '0;
            r_dir       <= DIR_UP;
            r_cont      <= 1'b0;
        end else if (w_cfg_latch) begin
            r_cfg_start <= i_fcw_start;
            r_cfg_stop  <= i_fcw_stop;
            r_step_eff  <= w_in_step_eff;
            r_dwell_eff <= w_in_dwell_eff;
            r_dir       <= (i_fcw_stop >= i_fcw_start) ? DIR_UP : DIR_DOWN;
            r_cont      <= i_continuous;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    w_state_nxt = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_cnt_zero && w_at_stop && !r_cont) begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        w_fcw_nxt       = r_fcw;
        w_valid_nxt     = 1'b0;
        w_phase_clr_nxt = 1'b0;
        w_step_nxt      = 1'b0;
        w_done_nxt      = 1'b0;
        w_cfg_latch     = 1'b0;
        w_cnt_load      = 1'b0;
        w_cnt_load_val  = r_dwell_eff - DWELL_W'(1);
        w_cnt_dec       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    w_cfg_latch     = 1'b1;
                    w_fcw_nxt       = i_fcw_start;
                    w_valid_nxt     = 1'b1;
                    w_phase_clr_nxt = 1'b1;
                    w_cnt_load      = 1'b1;
                    w_cnt_load_val  = w_in_dwell_eff - DWELL_W'(1);
                end
            end
            ST_DWELL: begin
                if (i_abort) begin
                    w_valid_nxt = 1'b0;
                end else if (!w_cnt_zero) begin
                    w_valid_nxt = 1'b1;
                    w_cnt_dec   = 1'b1;
                end else if (w_at_stop) begin
                    if (r_cont) begin
                        w_fcw_nxt       = r_cfg_start;
                        w_valid_nxt     = 1'b1;
                        w_phase_clr_nxt = 1'b1;
                        w_cnt_load      = 1'b1;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end else begin
                    w_fcw_nxt   = w_step_word;
                    w_valid_nxt = 1'b1;
                    w_step_nxt  = 1'b1;
                    w_cnt_load  = 1'b1;
                end
            end
        endcase
    end

    assign o_fcw       = r_fcw;
    assign o_fcw_valid = r_fcw_valid;
    assign o_phase_clr = r_phase_clr;
    assign o_step      = r_step;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule : nco_sweep_ctrl
`default_nettype wire

// File: tb/tb_nco_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nco_sweep_ctrl
// Description : Directed-vector bench for nco_sweep_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nco_sweep_ctrl;

    localparam int C_FCW_W   = 8;
    localparam int C_DWELL_W = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 i_start = 1'b0;
    logic                 i_abort = 1'b0;
    logic                 i_continuous = 1'b0;
    logic [C_FCW_W-1:0]   i_fcw_start = '0;
    logic [C_FCW_W-1:0]   i_fcw_stop = '0;
    logic [C_FCW_W-1:0]   i_fcw_step = '0;
    logic [C_DWELL_W-1:0] i_dwell = '0;
    logic [C_FCW_W-1:0]   o_fcw;
    logic                 o_fcw_valid;
    logic                 o_phase_clr;
    logic                 o_step;
    logic                 o_busy;
    logic                 o_done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    nco_sweep_ctrl #(
        .FCW_W   (C_FCW_W),
        .DWELL_W (C_DWELL_W)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_continuous (i_continuous),
        .i_fcw_start  (i_fcw_start),
        .i_fcw_stop   (i_fcw_stop),
        .i_fcw_step   (i_fcw_step),
        .i_dwell      (i_dwell),
        .o_fcw        (o_fcw),
        .o_fcw_valid  (o_fcw_valid),
        .o_phase_clr  (o_phase_clr),
        .o_step       (o_step),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    // One sweep: config inputs plus the hand-computed word sequence it yields.
    typedef struct packed {
        logic [7:0]      fcw_start;
        logic [7:0]      fcw_stop;
        logic [7:0]      fcw_step;
        logic [15:0]     dwell;
        logic            poke;
        logic [3:0][7:0] words;
        logic [2:0]      n_words;
        logic [3:0]      dwell_eff;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic chk_out(input string tag, input logic [7:0] fcw, input logic valid,
                           input logic pclr, input logic stp, input logic busy, input logic done);
        chk({tag, ".fcw"},       32'(o_fcw),       32'(fcw));
        chk({tag, ".valid"},     32'(o_fcw_valid), 32'(valid));
        chk({tag, ".phase_clr"}, 32'(o_phase_clr), 32'(pclr));
        chk({tag, ".step"},      32'(o_step),      32'(stp));
        chk({tag, ".busy"},      32'(o_busy),      32'(busy));
        chk({tag, ".done"},      32'(o_done),      32'(done));
    endtask

    task automatic cfg(input logic [7:0] st, input logic [7:0] sp, input logic [7:0] stp,
                       input logic [15:0] dw, input logic cont);
        i_fcw_start  = st;
        i_fcw_stop   = sp;
        i_fcw_step   = stp;
        i_dwell      = dw;
        i_continuous = cont;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{fcw_start: 8'd10,  fcw_stop: 8'd20,  fcw_step: 8'd5,  dwell: 16'd4, poke: 1'b0,
                    words: {8'd0, 8'd20, 8'd15, 8'd10},   n_words: 3'd3, dwell_eff: 4'd4};
        vecs[1] = '{fcw_start: 8'd200, fcw_stop: 8'd190, fcw_step: 8'd7,  dwell: 16'd1, poke: 1'b0,
                    words: {8'd0, 8'd190, 8'd193, 8'd200}, n_words: 3'd3, dwell_eff: 4'd1};
        vecs[2] = '{fcw_start: 8'd250, fcw_stop: 8'd255, fcw_step: 8'd10, dwell: 16'd2, poke: 1'b0,
                    words: {8'd0, 8'd0, 8'd255, 8'd250},  n_words: 3'd2, dwell_eff: 4'd2};
        vecs[3] = '{fcw_start: 8'd77,  fcw_stop: 8'd77,  fcw_step: 8'd9,  dwell: 16'd3, poke: 1'b0,
                    words: {8'd0, 8'd0, 8'd0, 8'd77},     n_words: 3'd1, dwell_eff: 4'd3};
        vecs[4] = '{fcw_start: 8'd3,   fcw_stop: 8'd5,   fcw_step: 8'd0,  dwell: 16'd0, poke: 1'b0,
                    words: {8'd0, 8'd5, 8'd4, 8'd3},      n_words: 3'd3, dwell_eff: 4'd1};
        vecs[5] = '{fcw_start: 8'd10,  fcw_stop: 8'd20,  fcw_step: 8'd5,  dwell: 16'd4, poke: 1'b1,
                    words: {8'd0, 8'd20, 8'd15, 8'd10},   n_words: 3'd3, dwell_eff: 4'd4};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk_out("reset", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk_out("post_reset", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Single-shot sweeps from the table
        for (int v = 0; v < 6; v++) begin
            cfg(vecs[v].fcw_start, vecs[v].fcw_stop, vecs[v].fcw_step, vecs[v].dwell, 1'b0);
            pulse_start();
            for (int w = 0; w < int'(vecs[v].n_words); w++) begin
                for (int c = 0; c < int'(vecs[v].dwell_eff); c++) begin
                    chk_out($sformatf("v%0d.w%0d.c%0d", v, w, c), vecs[v].words[w], 1'b1,
                            (w == 0 && c == 0), (w > 0 && c == 0), 1'b1, 1'b0);
                    if (vecs[v].poke && w == 0 && c == 1) begin
                        // Start and config changes while busy must be ignored
                        cfg(8'd99, 8'd0, 8'd1, 16'd1, 1'b1);
                        i_start = 1'b1;
                    end
                    @(negedge clk);
                    i_start = 1'b0;
                end
            end
            chk_out($sformatf("v%0d.done", v), vecs[v].words[vecs[v].n_words - 3'd1],
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
            chk_out($sformatf("v%0d.idle", v), vecs[v].words[vecs[v].n_words - 3'd1],
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Continuous 3,4,5 repeating, one cycle each, then abort
        cfg(8'd3, 8'd5, 8'd0, 16'd0, 1'b1);
        pulse_start();
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
                chk_out($sformatf("cont.r%0d.k%0d", r, k), 8'(3 + k), 1'b1,
                        (k == 0), (k != 0), 1'b1, 1'b0);
                @(negedge clk);
            end
        end
        chk_out("cont.tail", 8'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk_out("cont.pre_abort", 8'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        chk_out("cont.abort", 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Abort mid-sweep then restart from the start word
        cfg(8'd10, 8'd20, 8'd5, 16'd4, 1'b0);
        pulse_start();
        repeat (4) @(negedge clk);
        chk_out("abort.mid", 8'd15, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        chk_out("abort.next", 8'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_out("abort.hold", 8'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse_start();
        chk_out("abort.restart", 8'd10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        // Synchronous reset mid-sweep
        repeat (5) @(negedge clk);
        chk_out("rst.pre", 8'd15, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk_out("rst.mid", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_out("rst.idle", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Abort and start together in idle stays idle
        cfg(8'd40, 8'd50, 8'd1, 16'd1, 1'b0);
        i_abort = 1'b1;
        i_start = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        i_start = 1'b0;
        chk_out("abort_start", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_nco_sweep_ctrl
`default_nettype wire
